button_repeat_ctrl: RTL and testbench
=====================================

BUTTON_REPEAT_CTRL -- requirements
Module: button_repeat_ctrl

Interface
REQ-001 The module SHALL have parameter DB_CYCLES, default 1_000_000, meaning the number of consecutive clock cycles a synchronized input must differ from its debounced level before that level changes (10 ms at 100 MHz).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning the number of cycles from the first pulse to the first auto-repeat pulse (500 ms).
REQ-003 The module SHALL have parameter RPT_CYCLES, default 10_000_000, meaning the number of cycles between successive auto-repeat pulses (100 ms).
REQ-004 The module SHALL have port clk_100MHz, input, 1 bit: the single system clock.
REQ-005 The module SHALL have port reset, input, 1 bit: a synchronous, active-high reset.
REQ-006 The module SHALL have port btn_raw, input, 4 bits, asynchronous raw buttons, where [0]=inc hour, [1]=dec hour, [2]=inc minute and [3]=dec minute.
REQ-007 The module SHALL have port btn_level, output, 4 bits: the debounced level per button, in the same bit order as btn_raw.
REQ-008 The module SHALL have ports inc_hr, dec_hr, inc_min and dec_min, each an output of 1 bit carrying single-cycle step pulses for the clock/calendar set inputs.
REQ-009 All outputs SHALL be registered.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have its own debounce counter, ceil(log2(DB_CYCLES+1)) bits wide.
REQ-012 The debounce counter SHALL clear in any cycle where the synchronized bit equals btn_level.
REQ-013 The debounce counter SHALL increment while the synchronized bit differs from btn_level, and btn_level SHALL toggle on the edge at which the counter would reach DB_CYCLES; the counter then clears.
REQ-014 A single-cycle glitch shorter than DB_CYCLES SHALL never change btn_level.
REQ-015 Each button SHALL have a per-button FSM with states IDLE, FIRST, HOLD, REPEAT and LOCK.
REQ-016 In IDLE, a rising btn_level with the partner low SHALL move the FSM to FIRST; the partner pairs are 0/1 and 2/3.
REQ-017 FIRST SHALL assert the button's pulse output for exactly one cycle, clear the repeat counter, and move to HOLD.
REQ-018 HOLD SHALL count cycles and, when HOLD_CYCLES cycles have elapsed since the FIRST pulse, pulse once and enter REPEAT.
REQ-019 REPEAT SHALL pulse once every RPT_CYCLES cycles for as long as btn_level stays high.
REQ-020 In FIRST, HOLD or REPEAT, a falling btn_level SHALL return the FSM to IDLE on the next edge with no further pulse, even if a repeat pulse was due that same cycle.
REQ-021 If the partner btn_level is high while the FSM is in IDLE, FIRST, HOLD or REPEAT and own btn_level is high, the FSM SHALL go to LOCK, and any pulse due that cycle SHALL be suppressed.
REQ-022 LOCK SHALL emit nothing and SHALL return to IDLE only once own btn_level is low.
REQ-023 When both buttons of a pair rise in the same cycle, both FSMs SHALL enter LOCK and neither SHALL pulse.
REQ-024 Pairs SHALL be independent: inc_hr and inc_min may pulse in the same cycle.
REQ-025 Latency: if btn_raw[n] rises and stays high, btn_level[n] SHALL rise DB_CYCLES+2 edges after the first sampling edge, and the pulse SHALL appear one edge later.
REQ-026 There SHALL be no pulse on release.
REQ-027 The repeat counter SHALL be ceil(log2(max(HOLD_CYCLES,RPT_CYCLES)+1)) bits wide and SHALL saturate rather than wrap.

Reset
REQ-028 While reset is high at a clock edge, synchronizer flops, debounce counters, repeat counters and btn_level SHALL go to 0, FSMs to IDLE, and all pulse outputs to 0.
REQ-029 A reset asserted mid-hold SHALL cancel the hold, producing no pulse in the reset cycle or after it.
REQ-030 After reset deasserts with a button already held high, that press SHALL be treated as a new press: debounce runs, then a single FIRST pulse is emitted.

Verification
All scenarios below use DB_CYCLES=4, HOLD_CYCLES=20, RPT_CYCLES=5.
REQ-031 Hold btn_raw[0] high for 60 cycles -> btn_level[0] rises at edge 6, and inc_hr pulses at edges 7, 27, 32, 37, ...; no other output pulses.
REQ-032 Drive 3-cycle high glitches on btn_raw[2] separated by 3 low cycles -> btn_level[2] stays 0 and inc_min is never asserted.
REQ-033 Hold btn_raw[0], then press btn_raw[1] 10 cycles after the inc_hr pulse -> no further inc_hr or dec_hr pulses until both are released; a re-press of btn_raw[1] alone then yields one dec_hr pulse.
REQ-034 Press btn_raw[1] and btn_raw[3] simultaneously and hold 40 cycles -> dec_hr and dec_min each pulse on the same cycles (7, 27, 32, 37).
REQ-035 Assert reset for 1 cycle at edge 15 during a held btn_raw[0] -> outputs are 0 at edge 15; inc_hr pulses again at edge 15+7=22; no stale repeat pulse.
REQ-036 Release btn_raw[0] exactly on the cycle its repeat pulse is due -> FSM returns to IDLE with no pulse after btn_level falls.

Source files
------------

// File: rtl/button_repeat_ctrl.sv
// button_repeat_ctrl
//   Turns four raw push buttons into debounced levels and single-cycle step
//   pulses, with hold-to-repeat behaviour.
//   Each button is synchronized, debounced, and fed to a small FSM that
//   emits a first pulse, waits HOLD_CYCLES, and then repeats every
//   RPT_CYCLES. The FSM locks out both buttons of an opposing pair
//   (inc/dec) while both are held.
//
// Ports
//   clk_100MHz : system clock
//   reset      : synchronous, active-high reset
//   btn_raw    : raw buttons [0]=inc hour [1]=dec hour [2]=inc min [3]=dec min
//   btn_level  : debounced level per button, same bit order as btn_raw
//   inc_hr, dec_hr, inc_min, dec_min : single-cycle step pulses
module button_repeat_ctrl #(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned RPT_CYCLES  = 10_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic       inc_hr,
  output logic       dec_hr,
  output logic       inc_min,
  output logic       dec_min
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int unsigned DW      = $clog2(DB_CYCLES + 1);
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  // Terminal counts: the level flips / a pulse fires on the edge at which
  // the counter would reach the full cycle count.
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_HOLD,
    S_REPEAT,
    S_LOCK
  } state_e;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] level_q;
  logic [3:0] level_d;
  logic [3:0] pulse;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_btn
    localparam int unsigned PARTNER = g ^ 1;

    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic          lvl_d;
    state_e        state_q;
    logic [CW-1:0] rpt_cnt_q;
    logic          pulse_q;
    logic          own;
    logic          par;

    assign own = level_q[g];
    assign par = level_q[PARTNER];

    // Debounce: count consecutive disagreeing samples, flip on terminal count.
    always_comb begin
      lvl_d    = level_q[g];
      db_cnt_d = '0;
      if (sync2_q[g] != level_q[g]) begin
        if (db_cnt_q == DB_LAST) begin
          lvl_d = ~level_q[g];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    assign level_d[g] = lvl_d;

    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_d;
      end
    end

    // The first pulse is registered on the IDLE->FIRST edge so it appears
    // one edge after btn_level rises; the counter then tracks edges since
    // the most recent pulse.
    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        state_q   <= S_IDLE;
        rpt_cnt_q <= '0;
        pulse_q   <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        unique case (state_q)
          S_IDLE: begin
            if (own) begin
              if (par) begin
                state_q <= S_LOCK;
              end else begin
                state_q   <= S_FIRST;
                pulse_q   <= 1'b1;
                rpt_cnt_q <= '0;
              end
            end
          end
          S_FIRST, S_HOLD: begin
            if (!own) begin
              state_q <= S_IDLE;
            end else if (par) begin
              state_q <= S_LOCK;
            end else if (rpt_cnt_q == HOLD_LAST) begin
              state_q   <= S_REPEAT;
              pulse_q   <= 1'b1;
              rpt_cnt_q <= '0;
            end else begin
              state_q   <= S_HOLD;
              rpt_cnt_q <= (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
            end
          end
          S_REPEAT: begin
            if (!own) begin
              state_q <= S_IDLE;
            end else if (par) begin
              state_q <= S_LOCK;
            end else if (rpt_cnt_q == RPT_LAST) begin
              pulse_q   <= 1'b1;
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
            end
          end
          S_LOCK: begin
            if (!own) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign pulse[g] = pulse_q;
  end

  assign btn_level = level_q;
  assign inc_hr    = pulse[0];
  assign dec_hr    = pulse[1];
  assign inc_min   = pulse[2];
  assign dec_min   = pulse[3];

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// tb_button_repeat_ctrl
//   Drives directed scenarios (long hold, glitches, pair lockout, opposing
//   pairs, reset mid-hold, release around a repeat) followed by randomized
//   button activity, and compares btn_level and the four pulse outputs on
//   every cycle against a behavioural model built from press timestamps.
module tb_button_repeat_ctrl;

  localparam int DB = 4;
  localparam int H  = 20;
  localparam int R  = 5;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic       inc_hr;
  logic       dec_hr;
  logic       inc_min;
  logic       dec_min;

  button_repeat_ctrl #(
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(H),
    .RPT_CYCLES (R)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .inc_hr    (inc_hr),
    .dec_hr    (dec_hr),
    .inc_min   (inc_min),
    .dec_min   (dec_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int edge_n;

  // Reference model state
  logic [3:0] m_s1;
  logic [3:0] m_s2;
  logic [3:0] m_lvl;
  logic [3:0] m_pulse;
  int         m_run  [4];
  int         m_mode [4];   // 0 = released, 1 = pressed (timestamped), 2 = locked out
  int         m_t    [4];   // edge at which the first pulse of the press fired

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %b expected %b", tag, edge_n, got, exp);
    end
  endtask

  // One clock edge of the behavioural model. Pulses are decided from the
  // debounced levels before the edge; timing of repeats is computed from
  // the elapsed edges since the press.
  task automatic model_edge(input logic [3:0] raw, input logic rst);
    logic [3:0] old;
    edge_n++;
    if (rst) begin
      m_s1    = '0;
      m_s2    = '0;
      m_lvl   = '0;
      m_pulse = '0;
      for (int b = 0; b < 4; b++) begin
        m_run[b]  = 0;
        m_mode[b] = 0;
        m_t[b]    = 0;
      end
      return;
    end
    old = m_lvl;
    for (int b = 0; b < 4; b++) begin
      int  p;
      int  e;
      logic own;
      logic par;
      p   = b ^ 1;
      own = old[b];
      par = old[p];
      m_pulse[b] = 1'b0;
      case (m_mode[b])
        0: begin
          if (own && par) m_mode[b] = 2;
          else if (own) begin
            m_mode[b]  = 1;
            m_t[b]     = edge_n;
            m_pulse[b] = 1'b1;
          end
        end
        1: begin
          if (!own) m_mode[b] = 0;
          else if (par) m_mode[b] = 2;
          else begin
            e = edge_n - m_t[b];
            if (e == H || (e > H && (e - H) % R == 0)) m_pulse[b] = 1'b1;
          end
        end
        default: begin
          if (!own) m_mode[b] = 0;
        end
      endcase
    end
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_lvl[b] = ~m_lvl[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic step(input logic [3:0] raw, input logic rst);
    @(negedge clk);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
    chk("level", btn_level, m_lvl);
    chk("pulse", {dec_min, inc_min, dec_hr, inc_hr}, m_pulse);
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  initial begin
    int         rem [4];
    logic [3:0] rraw;
    n_vec   = 0;
    n_err   = 0;
    edge_n  = 0;
    btn_raw = '0;
    reset   = 1'b1;
    m_s1    = '0;
    m_s2    = '0;
    m_lvl   = '0;
    m_pulse = '0;
    for (int b = 0; b < 4; b++) begin
      m_run[b]  = 0;
      m_mode[b] = 0;
      m_t[b]    = 0;
    end

    // Reset state
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Long hold of inc hour: first pulse, hold delay, repeats
    hold(4'b0001, 60);
    hold(4'b0000, 12);

    // Short glitches on inc minute must never debounce
    for (int k = 0; k < 5; k++) begin
      hold(4'b0100, 3);
      hold(4'b0000, 3);
    end
    hold(4'b0000, 8);

    // Hold inc hour, add dec hour later, release both, then dec hour alone
    hold(4'b0001, 17);
    hold(4'b0011, 30);
    hold(4'b0000, 12);
    hold(4'b0010, 15);
    hold(4'b0000, 12);

    // Both hour buttons pressed together
    hold(4'b0011, 20);
    hold(4'b0000, 12);

    // Independent pairs: both decrements held together
    hold(4'b1010, 40);
    hold(4'b0000, 12);

    // Reset pulse in the middle of a hold, button stays down
    step(4'b0000, 1'b1);
    hold(4'b0001, 14);
    step(4'b0001, 1'b1);
    hold(4'b0001, 30);
    hold(4'b0000, 12);

    // Releases landing around the hold deadline and a repeat slot
    for (int len = 22; len <= 33; len++) begin
      hold(4'b0001, len);
      hold(4'b0000, 10);
    end

    // Randomized activity with varied run lengths and rare resets
    rraw = '0;
    for (int b = 0; b < 4; b++) rem[b] = $urandom_range(1, 45);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        rem[b]--;
        if (rem[b] <= 0) begin
          rraw[b] = ~rraw[b];
          rem[b]  = (($urandom & 3) == 0) ? int'($urandom_range(1, 5))
                                          : int'($urandom_range(6, 60));
        end
      end
      step(rraw, ($urandom_range(0, 299) == 0));
    end
    hold(4'b0000, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
